// File: rtl/sd_dir_scanner.sv
// Directory scan sequencer: reads consecutive sectors, slices them into 32-byte
// entries for the parser, counts reported records and captures one by index.
module sd_dir_scanner #(
  parameter logic [15:0] MAX_FILES = 16'hFFFF,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dir_sector,
  input  logic [15:0] dir_nsect,
  input  logic [15:0] sel_index,
  output logic        rd_req,
  output logic [31:0] rd_sector,
  input  logic        rd_ack,
  input  logic        rd_bvalid,
  input  logic [8:0]  rd_baddr,
  input  logic [7:0]  rd_bdata,
  input  logic        rd_done,
  input  logic        rd_err,
  output logic        p_rvalid,
  output logic [4:0]  p_raddr,
  output logic [7:0]  p_rdata,
  input  logic        p_fready,
  input  logic [15:0] p_fcluster,
  input  logic [31:0] p_fsize,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] file_count,
  output logic        sel_found,
  output logic [15:0] sel_cluster,
  output logic [31:0] sel_size
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] sel_idx_q, sel_idx_d;
  logic [7:0]  drain_q, drain_d;
  logic        end_q, end_d;
  logic        err_q, err_d;
  logic        rd_req_q, rd_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        p_rvalid_q, p_rvalid_d;
  logic [4:0]  p_raddr_q, p_raddr_d;
  logic [7:0]  p_rdata_q, p_rdata_d;
  logic [15:0] file_count_q, file_count_d;
  logic        sel_found_q, sel_found_d;
  logic [15:0] sel_cluster_q, sel_cluster_d;
  logic [31:0] sel_size_q, sel_size_d;
  logic        drain_last_s;

  assign drain_last_s = ({24'd0, drain_q} + 32'd1) >= DRAIN_CYC;

  // Next-state, scan bookkeeping, parser forwarding and record capture
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    sel_idx_d     = sel_idx_q;
    drain_d       = drain_q;
    end_d         = end_q;
    err_d         = err_q;
    p_rvalid_d    = 1'b0;
    p_raddr_d     = p_raddr_q;
    p_rdata_d     = p_rdata_q;
    file_count_d  = file_count_q;
    sel_found_d   = sel_found_q;
    sel_cluster_d = sel_cluster_q;
    sel_size_d    = sel_size_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d         = dir_sector;
          rem_d         = dir_nsect;
          sel_idx_d     = sel_index;
          file_count_d  = 16'd0;
          sel_found_d   = 1'b0;
          sel_cluster_d = 16'd0;
          sel_size_d    = 32'd0;
          err_d         = 1'b0;
          end_d         = 1'b0;
          state_d       = (dir_nsect == 16'd0) ? S_FIN : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (rd_ack) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_REQ;
        end
      end
      S_STREAM: begin
        // The end-marker byte itself still reaches the parser; everything after is dropped.
        if (rd_bvalid && !end_q) begin
          p_rvalid_d = 1'b1;
          p_raddr_d  = rd_baddr[4:0];
          p_rdata_d  = rd_bdata;
          end_d      = (rd_baddr[4:0] == 5'd0) && (rd_bdata == 8'h00);
        end else begin
          p_rvalid_d = 1'b0;
        end
        if (rd_err) begin
          err_d   = 1'b1;
          drain_d = 8'd0;
          state_d = S_DRAIN;
        end else if (rd_done) begin
          drain_d = 8'd0;
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (!drain_last_s) begin
          drain_d = drain_q + 8'd1;
        end else if (err_q || end_q || (rem_q == 16'd1)) begin
          state_d = S_FIN;
        end else begin
          ptr_d   = ptr_q + 32'd1;
          rem_d   = rem_q - 16'd1;
          state_d = S_REQ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy_q is only high outside IDLE, so this never collides with the start clear above
    if (busy_q && p_fready) begin
      if ((file_count_q == sel_idx_q) && !sel_found_q) begin
        sel_found_d   = 1'b1;
        sel_cluster_d = p_fcluster;
        sel_size_d    = p_fsize;
      end else begin
        sel_found_d = sel_found_q;
      end
      if (file_count_q != MAX_FILES) begin
        file_count_d = file_count_q + 16'd1;
      end else begin
        file_count_d = file_count_q;
      end
    end else begin
      file_count_d = file_count_d;
    end

    rd_req_d = (state_d == S_REQ);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= 32'd0;
      rem_q         <= 16'd0;
      sel_idx_q     <= 16'd0;
      drain_q       <= 8'd0;
      end_q         <= 1'b0;
      err_q         <= 1'b0;
      rd_req_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      p_rvalid_q    <= 1'b0;
      p_raddr_q     <= 5'd0;
      p_rdata_q     <= 8'd0;
      file_count_q  <= 16'd0;
      sel_found_q   <= 1'b0;
      sel_cluster_q <= 16'd0;
      sel_size_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      rem_q         <= rem_d;
      sel_idx_q     <= sel_idx_d;
      drain_q       <= drain_d;
      end_q         <= end_d;
      err_q         <= err_d;
      rd_req_q      <= rd_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      p_rvalid_q    <= p_rvalid_d;
      p_raddr_q     <= p_raddr_d;
      p_rdata_q     <= p_rdata_d;
      file_count_q  <= file_count_d;
      sel_found_q   <= sel_found_d;
      sel_cluster_q <= sel_cluster_d;
      sel_size_q    <= sel_size_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_sector   = ptr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign p_rvalid    = p_rvalid_q;
  assign p_raddr     = p_raddr_q;
  assign p_rdata     = p_rdata_q;
  assign file_count  = file_count_q;
  assign sel_found   = sel_found_q;
  assign sel_cluster = sel_cluster_q;
  assign sel_size    = sel_size_q;

endmodule

// File: tb/tb_sd_dir_scanner.sv
// Randomized scoreboard bench: a sector-reader model and parser model drive the
// scanner; expectations come from a reference walk over the directory image.
module tb_sd_dir_scanner;
  localparam int DRAIN = 2;
  localparam int ERR_BYTES = 100;

  typedef struct packed {
    logic [15:0] cnt;
    logic        found;
    logic [15:0] clu;
    logic [31:0] sz;
    logic        er;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] dir_sector = 32'd0;
  logic [15:0] dir_nsect = 16'd0, sel_index = 16'd0;
  logic rd_req, rd_ack, rd_bvalid, rd_done, rd_err;
  logic [31:0] rd_sector;
  logic [8:0] rd_baddr;
  logic [7:0] rd_bdata;
  logic p_rvalid, p_fready;
  logic [4:0] p_raddr;
  logic [7:0] p_rdata;
  logic [15:0] p_fcluster;
  logic [31:0] p_fsize;
  logic busy, done, err, sel_found;
  logic [15:0] file_count, sel_cluster;
  logic [31:0] sel_size;

  sd_dir_scanner #(.MAX_FILES(16'hFFFF), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir_sector(dir_sector),
    .dir_nsect(dir_nsect), .sel_index(sel_index), .rd_req(rd_req),
    .rd_sector(rd_sector), .rd_ack(rd_ack), .rd_bvalid(rd_bvalid),
    .rd_baddr(rd_baddr), .rd_bdata(rd_bdata), .rd_done(rd_done), .rd_err(rd_err),
    .p_rvalid(p_rvalid), .p_raddr(p_raddr), .p_rdata(p_rdata),
    .p_fready(p_fready), .p_fcluster(p_fcluster), .p_fsize(p_fsize),
    .busy(busy), .done(done), .err(err), .file_count(file_count),
    .sel_found(sel_found), .sel_cluster(sel_cluster), .sel_size(sel_size));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int start_cyc = 0, last_end_cyc = 0, done_cnt = 0, bytes_seen = 0;
  bit last_end_valid = 1'b0, rdr_abort = 1'b0, rdr_busy = 1'b0;
  logic [31:0] cur_base = 32'd0;
  int cur_err_sect = -1;
  logic [7:0] mem [0:2047];
  logic [31:0] exp_sec_q[$];
  logic [12:0] exp_byte_q[$];
  res_t exp_res_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sector reader model: random ack delay, stray bytes before ack, gappy byte stream
  initial begin
    logic [31:0] rel;
    int nb, off;
    bit fin;
    rd_ack = 1'b0; rd_bvalid = 1'b0; rd_baddr = 9'd0; rd_bdata = 8'd0;
    rd_done = 1'b0; rd_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && !rdr_abort && rd_req) begin
        rdr_busy = 1'b1;
        repeat ($urandom_range(0, 2)) begin
          rd_bvalid = 1'b1; rd_baddr = 9'd0; rd_bdata = 8'h00;
          @(negedge clk);
        end
        rd_bvalid = 1'b0;
        rd_ack = 1'b1;
        rel = rd_sector - cur_base;
        if (rel > 32'd3) rel = 32'd0;
        @(negedge clk);
        rd_ack = 1'b0;
        nb = (int'(rel) == cur_err_sect) ? ERR_BYTES : 512;
        off = 0; fin = 1'b0;
        while (!fin && !rdr_abort) begin
          rd_done = 1'b0; rd_err = 1'b0; rd_bvalid = 1'b0;
          if (off < nb) begin
            if ($urandom_range(0, 3) != 0) begin
              rd_bvalid = 1'b1;
              rd_baddr = off[8:0];
              rd_bdata = mem[int'(rel) * 512 + off];
              off++;
              if (off == 512 && $urandom_range(0, 1) == 1) begin
                rd_done = 1'b1; fin = 1'b1;
              end
            end
          end else begin
            if (nb == 512) rd_done = 1'b1;
            else rd_err = 1'b1;
            fin = 1'b1;
          end
          if (fin) begin
            last_end_cyc = cyc; last_end_valid = 1'b1;
          end
          @(negedge clk);
        end
        rd_bvalid = 1'b0; rd_done = 1'b0; rd_err = 1'b0; rd_ack = 1'b0;
        rdr_busy = 1'b0;
      end
    end
  end

  // parser model: an entry whose first byte is 'F' is a file record
  initial begin
    logic [7:0] pbuf [0:31];
    p_fready = 1'b0; p_fcluster = 16'd0; p_fsize = 32'd0;
    forever begin
      @(negedge clk);
      p_fready = 1'b0;
      if (rst_n && p_rvalid) begin
        pbuf[p_raddr] = p_rdata;
        if (p_raddr == 5'd31 && pbuf[0] == 8'h46) begin
          p_fready = 1'b1;
          p_fcluster = {pbuf[27], pbuf[26]};
          p_fsize = {pbuf[31], pbuf[30], pbuf[29], pbuf[28]};
        end
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a request, byte or done
  initial begin
    bit req_prev = 1'b0;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_req && !req_prev) begin
          if (exp_sec_q.size() == 0) chk("extra_rd_req", 64'd1, 64'd0);
          else begin
            chk("rd_sector", 64'(rd_sector), 64'(exp_sec_q.pop_front()));
            if (last_end_valid) chk("req_latency", 64'(cyc - last_end_cyc), 64'(DRAIN + 1));
            else chk("req_after_start", 64'(cyc - start_cyc), 64'd1);
          end
        end
        if (p_rvalid) begin
          bytes_seen++;
          if (exp_byte_q.size() == 0) chk("extra_p_byte", {51'd0, p_raddr, p_rdata}, 64'd0);
          else chk("p_byte", {51'd0, p_raddr, p_rdata}, 64'(exp_byte_q.pop_front()));
        end
        if (done) begin
          done_cnt++;
          if (exp_res_q.size() == 0) chk("extra_done", 64'd1, 64'd0);
          else begin
            r = exp_res_q.pop_front();
            chk("file_count", 64'(file_count), 64'(r.cnt));
            chk("sel_found", 64'(sel_found), 64'(r.found));
            chk("sel_cluster", 64'(sel_cluster), 64'(r.clu));
            chk("sel_size", 64'(sel_size), 64'(r.sz));
            chk("err", 64'(err), 64'(r.er));
            chk("busy_at_done", 64'(busy), 64'd1);
            if (last_end_valid) chk("done_latency", 64'(cyc - last_end_cyc), 64'(DRAIN + 1));
            else chk("done_latency_empty", 64'((cyc - start_cyc) <= 2), 64'd1);
          end
        end
        req_prev = rd_req;
      end else begin
        req_prev = 1'b0;
      end
    end
  end

  task automatic fill(input int pct);
    for (int e = 0; e < 64; e++) begin
      mem[e * 32] = ($urandom_range(0, 99) < pct) ? 8'h46 : 8'(8'h41 + $urandom_range(0, 4));
      for (int b = 1; b < 32; b++) mem[e * 32 + b] = 8'($urandom);
    end
  endtask

  task automatic put_rec(input int e, input logic [15:0] clu, input logic [31:0] sz);
    mem[e * 32] = 8'h46;
    mem[e * 32 + 26] = clu[7:0];   mem[e * 32 + 27] = clu[15:8];
    mem[e * 32 + 28] = sz[7:0];    mem[e * 32 + 29] = sz[15:8];
    mem[e * 32 + 30] = sz[23:16];  mem[e * 32 + 31] = sz[31:24];
  endtask

  task automatic flush();
    exp_sec_q.delete(); exp_byte_q.delete(); exp_res_q.delete();
  endtask

  task automatic run_scan(input logic [31:0] base, input int nsect, input logic [15:0] sel,
                          input int err_sect, input bit poke, input int rst_at);
    logic [7:0] ebuf [0:31];
    logic [7:0] b;
    bit endf = 1'b0, stop = 1'b0;
    int nrec = 0, n = 0, d0, b0;
    res_t r = '0;
    // reference walk: sector by sector, stop on end marker or read error
    for (int s = 0; s < nsect && !stop; s++) begin
      exp_sec_q.push_back(base + 32'(s));
      for (int o = 0; o < ((s == err_sect) ? ERR_BYTES : 512); o++) begin
        b = mem[s * 512 + o];
        if (!endf) begin
          exp_byte_q.push_back({o[4:0], b});
          ebuf[o % 32] = b;
          if (o % 32 == 0 && b == 8'h00) endf = 1'b1;
          else if (o % 32 == 31 && ebuf[0] == 8'h46) begin
            if (nrec == int'(sel)) begin
              r.found = 1'b1;
              r.clu = {ebuf[27], ebuf[26]};
              r.sz = {ebuf[31], ebuf[30], ebuf[29], ebuf[28]};
            end
            nrec++;
          end
        end
      end
      if (s == err_sect) begin r.er = 1'b1; stop = 1'b1; end
      else if (endf) stop = 1'b1;
    end
    r.cnt = (nrec > 65535) ? 16'hFFFF : 16'(nrec);
    exp_res_q.push_back(r);
    cur_base = base; cur_err_sect = err_sect;
    @(negedge clk);
    last_end_valid = 1'b0;
    dir_sector = base; dir_nsect = 16'(nsect); sel_index = sel; start = 1'b1;
    start_cyc = cyc; d0 = done_cnt; b0 = bytes_seen;
    @(negedge clk);
    start = 1'b0; dir_sector = $urandom; dir_nsect = 16'($urandom_range(1, 4));
    while (done_cnt == d0 && n < 1000 * (nsect + 1) + 100) begin
      if (rst_at > 0 && bytes_seen - b0 >= rst_at) begin
        rdr_abort = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_p_rvalid", 64'(p_rvalid), 64'd0);
        chk("rst_rd_sector", 64'(rd_sector), 64'd0);
        chk("rst_p_bus", {51'd0, p_raddr, p_rdata}, 64'd0);
        chk("rst_file_count", 64'(file_count), 64'd0);
        chk("rst_sel", {15'd0, sel_found, sel_cluster, sel_size}, 64'd0);
        chk("rst_done_err", {62'd0, done, err}, 64'd0);
        flush();
        n = 0;
        while (rdr_busy && n < 10) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rdr_abort = 1'b0; last_end_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        return;
      end
      @(negedge clk);
      n++;
      start = (poke && n == 30);
    end
    start = 1'b0;
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    repeat (2) @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("err_hold", 64'(err), 64'(r.er));
    chk("count_hold", 64'(file_count), 64'(r.cnt));
    chk("sectors_left", 64'(exp_sec_q.size()), 64'd0);
    chk("bytes_left", 64'(exp_byte_q.size()), 64'd0);
    flush();
  endtask

  initial begin
    int ns, es;
    repeat (3) @(negedge clk);
    chk("reset_outs", {59'd0, rd_req, p_rvalid, busy, done, err}, 64'd0);
    chk("reset_sector", 64'(rd_sector), 64'd0);
    chk("reset_results", {15'd0, sel_found, file_count, sel_cluster}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(0);
    put_rec(0, 16'd11, 32'd100); put_rec(3, 16'd12, 32'd200); put_rec(17, 16'd13, 32'd300);
    put_rec(20, 16'd14, 32'd400); put_rec(31, 16'd15, 32'd500);
    run_scan(32'd100, 2, 16'd4, -1, 1'b0, 0);

    fill(30); mem[64] = 8'h00;
    run_scan(32'd200, 4, 16'd1, -1, 1'b0, 0);

    fill(0);
    put_rec(1, 16'd3, 32'd10); put_rec(5, 16'd7, 32'd20); put_rec(9, 16'd9, 32'd30);
    run_scan(32'd300, 1, 16'd2, -1, 1'b0, 0);
    run_scan(32'd300, 1, 16'd7, -1, 1'b0, 0);

    fill(30);
    run_scan(32'd400, 3, 16'd0, 1, 1'b0, 0);
    run_scan(32'd500, 0, 16'd0, -1, 1'b0, 0);
    run_scan(32'd600, 2, 16'd1, -1, 1'b1, 0);
    run_scan(32'd700, 2, 16'd0, -1, 1'b0, 40);
    fill(30);
    run_scan(32'd800, 1, 16'd3, -1, 1'b0, 0);

    for (int i = 0; i < 5; i++) begin
      fill($urandom_range(0, 50));
      ns = $urandom_range(1, 4);
      es = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ns - 1) : -1;
      if ($urandom_range(0, 2) == 0) mem[$urandom_range(0, 63) * 32] = 8'h00;
      run_scan((i == 0) ? 32'hFFFF_FFFF : $urandom, ns, 16'($urandom_range(0, 6)), es, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
